// File: rtl/arch_regfile.sv
// Architectural register file with rename status. Each register holds committed data,
// plus a pending bit and the ROB tag of the youngest in-flight writer.
module arch_regfile #(
   parameter int REG_WIDTH = 5,
   parameter int ROB_WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   reset_b,
   input  logic [REG_WIDTH-1:0]   read_num [2],
   output logic [ROB_WIDTH+32:0]  arch_read [2],
   input  logic                   issue,
   input  logic                   issue_writes,
   input  logic [REG_WIDTH-1:0]   issue_r0,
   input  logic [ROB_WIDTH-1:0]   issue_tag,
   input  logic                   commit,
   input  logic [REG_WIDTH-1:0]   commit_arch_num,
   input  logic [ROB_WIDTH-1:0]   commit_tag,
   input  logic [31:0]            commit_data,
   input  logic                   flush,
   output logic                   idle
);

   localparam int NUM_REGS = 2 ** REG_WIDTH;

   logic [31:0]          data_q    [NUM_REGS];
   logic [ROB_WIDTH-1:0] tag_q     [NUM_REGS];
   logic [NUM_REGS-1:0]  pending_q;

   // Rename is placed after the commit clear so that, on the same register, it wins.
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
         pending_q <= '0;
      end else begin
         if (commit)
            data_q[commit_arch_num] <= commit_data;
         if (flush) begin
            pending_q <= '0;
         end else begin
            if (commit && (tag_q[commit_arch_num] == commit_tag))
               pending_q[commit_arch_num] <= 1'b0;
            if (issue && issue_writes) begin
               pending_q[issue_r0] <= 1'b1;
               tag_q[issue_r0]     <= issue_tag;
            end
         end
      end
   end

   // Read layout: {valid, tag, data}; reads see pre-edge state.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         arch_read[p] = {~pending_q[read_num[p]], tag_q[read_num[p]], data_q[read_num[p]]};
      end
   end

   assign idle = ~|pending_q;

endmodule
